// File: rtl/alu_mul_seq_if.sv
// Request/response handshake and shared-ALU bus for the multiply sequencer.
// The master side is the requester and ALU owner. The slave side is the sequencer.
interface alu_mul_seq_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic                  req_hi;
  logic                  kill;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  alu_busy;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_eq;

  modport master (
    output req_valid, req_a, req_b, req_hi, kill, resp_ready, alu_out, alu_eq,
    input  req_ready, resp_valid, resp_data, alu_busy, alu_op1, alu_op2, alu_ctrl
  );

  modport slave (
    input  req_valid, req_a, req_b, req_hi, kill, resp_ready, alu_out, alu_eq,
    output req_ready, resp_valid, resp_data, alu_busy, alu_op1, alu_op2, alu_ctrl
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that drives the shared combinational ALU for DATA_WIDTH iterations.
// The low or high product word is returned over a valid/ready handshake. All outputs are registered.
module alu_mul_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_mul_seq_if.slave bus
);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {IDLE, ZCHK, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] p_hi_q, p_hi_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hi_sel_q, hi_sel_d;
  logic                  carry;

  logic                  req_ready_d, resp_valid_d, alu_busy_d;
  logic [DATA_WIDTH-1:0] resp_data_d, alu_op1_d, alu_op2_d;
  logic [2:0]            alu_ctrl_d;

  // Next state and datapath.
  always_comb begin
    state_d  = state_q;
    p_hi_d   = p_hi_q;
    m_d      = m_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    hi_sel_d = hi_sel_q;
    carry    = (bus.alu_out < p_hi_q);

    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          a_d      = bus.req_a;
          m_d      = bus.req_b;
          hi_sel_d = bus.req_hi;
          p_hi_d   = '0;
          cnt_d    = '0;
          state_d  = ZCHK;
        end
      end
      ZCHK: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (bus.alu_eq) begin
          p_hi_d  = '0;
          m_d     = '0;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          // Shift the {carry, partial sum, multiplier} chain right by one bit.
          if (m_q[0]) begin
            p_hi_d = {carry, bus.alu_out[DATA_WIDTH-1:1]};
            m_d    = {bus.alu_out[0], m_q[DATA_WIDTH-1:1]};
          end else begin
            p_hi_d = {1'b0, p_hi_q[DATA_WIDTH-1:1]};
            m_d    = {p_hi_q[0], m_q[DATA_WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.kill || bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the next state so the ALU sees its operands in the owning cycle.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    alu_busy_d   = (state_d == ZCHK) || (state_d == RUN);
    alu_ctrl_d   = ALU_ADD;
    alu_op1_d    = '0;
    alu_op2_d    = '0;
    resp_valid_d = (state_d == DONE);
    resp_data_d  = '0;
    if (state_d == ZCHK) begin
      alu_ctrl_d = ALU_EQ;
      alu_op1_d  = m_d;
    end
    if (state_d == RUN) begin
      alu_op1_d = p_hi_d;
      alu_op2_d = a_d;
    end
    if (state_d == DONE) begin
      resp_data_d = hi_sel_d ? p_hi_d : m_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      p_hi_q         <= '0;
      m_q            <= '0;
      a_q            <= '0;
      cnt_q          <= '0;
      hi_sel_q       <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.alu_busy   <= 1'b0;
      bus.alu_op1    <= '0;
      bus.alu_op2    <= '0;
      bus.alu_ctrl   <= ALU_ADD;
    end else begin
      state_q        <= state_d;
      p_hi_q         <= p_hi_d;
      m_q            <= m_d;
      a_q            <= a_d;
      cnt_q          <= cnt_d;
      hi_sel_q       <= hi_sel_d;
      bus.req_ready  <= req_ready_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_data  <= resp_data_d;
      bus.alu_busy   <= alu_busy_d;
      bus.alu_op1    <= alu_op1_d;
      bus.alu_op2    <= alu_op2_d;
      bus.alu_ctrl   <= alu_ctrl_d;
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq, with a behavioural ALU and a 64-bit product model.
module tb_alu_mul_seq;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_mul_seq_if #(.DATA_WIDTH(W)) bus ();

  alu_mul_seq #(.DATA_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared ALU: adds on ctrl 000, compares operands for the equality flag.
  assign bus.alu_out = (bus.alu_ctrl == 3'b000) ? (bus.alu_op1 + bus.alu_op2) : '0;
  assign bus.alu_eq  = (bus.alu_op1 == bus.alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, then check latency, ALU ownership, the result and the handshake.
  task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic hi,
                        input int hold, input string tag);
    logic [63:0]   prod;
    logic [W-1:0]  exp_data;
    logic [W-1:0]  held;
    int            exp_lat;
    int            lat;
    int            zc;
    int            rc;
    prod     = {32'b0, a} * {32'b0, b};
    exp_data = hi ? prod[63:32] : prod[31:0];
    exp_lat  = (b == '0) ? 2 : W + 2;
    check({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_hi    = hi;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_hi    = 1'($urandom_range(0, 1));
    lat = 1;
    zc  = 0;
    rc  = 0;
    while (!bus.resp_valid && lat < 100) begin
      if (bus.alu_busy && bus.alu_ctrl == 3'b111) zc++;
      if (bus.alu_busy && bus.alu_ctrl == 3'b000) rc++;
      step();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(bus.resp_data), 64'(exp_data));
    check({tag, "_zchk"}, 64'(zc), 64'd1);
    check({tag, "_run"}, 64'(rc), (b == '0) ? 64'd0 : 64'(W));
    held = bus.resp_data;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hvld"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hrdy"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_hdat"}, 64'(bus.resp_data), 64'(held));
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check({tag, "_vld0"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_rdy1"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Watch for a stray response over a window of cycles.
  task automatic no_resp(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.resp_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_data"}, 64'(bus.resp_data), 64'd0);
    check({tag, "_busy"}, 64'(bus.alu_busy), 64'd0);
    check({tag, "_op1"}, 64'(bus.alu_op1), 64'd0);
    check({tag, "_op2"}, 64'(bus.alu_op2), 64'd0);
    check({tag, "_ctrl"}, 64'(bus.alu_ctrl), 64'd0);
    check({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_hi     = 1'b0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    mul_op(32'd3, 32'd5, 1'b0, 0, "m3x5");
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "ffhi");
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "fflo");
    mul_op(32'd7, 32'd0, 1'b0, 0, "bzero");
    mul_op(32'd0, 32'd9, 1'b0, 0, "azero");
    mul_op(32'h0001_0000, 32'h0001_0000, 1'b1, 5, "hold");

    // Abort in the fourth RUN iteration, then try to start with kill still high.
    bus.req_a     = 32'h1357_9BDF;
    bus.req_b     = 32'h0000_1234;
    bus.req_hi    = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (4) step();
    bus.kill = 1'b1;
    step();
    check("kill_vld", 64'(bus.resp_valid), 64'd0);
    check("kill_busy", 64'(bus.alu_busy), 64'd0);
    check("kill_rdy", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    check("kidle_busy", 64'(bus.alu_busy), 64'd0);
    check("kidle_rdy", 64'(bus.req_ready), 64'd1);
    no_resp(40, "kill_noresp");

    // Reset in the middle of the eleventh RUN iteration.
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'hCAFE_F00D;
    bus.req_hi    = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (11) step();
    check("pre_rst_busy", 64'(bus.alu_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mrst");
    step();
    rst_n = 1'b1;
    no_resp(40, "rst_noresp");
    mul_op(32'd6, 32'd7, 1'b0, 0, "r6x7");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      mul_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiply sequencer that borrows the shared combinational ALU (ADD ctrl 3'b000, EQ ctrl 3'b111) and drives it iteratively.
- Shift-add algorithm, 32 iterations; returns low (MUL) or high (MULHU) word of the 64-bit product over a valid/ready handshake.
- Sits beside the ALU in the execute stage. The top-level mux hands ALU operand/ctrl inputs to this block while alu_busy=1.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count = DATA_WIDTH.
- CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  multiply request.
- req_ready  out  1  high only in IDLE.
- req_a  in  DATA_WIDTH  multiplicand.
- req_b  in  DATA_WIDTH  multiplier.
- req_hi  in  1  0 = return low word, 1 = return high word.
- kill  in  1  synchronous abort (pipeline flush).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DATA_WIDTH  selected product word.
- alu_busy  out  1  block owns the ALU this cycle.
- alu_op1  out  DATA_WIDTH  ALU operand 1.
- alu_op2  out  DATA_WIDTH  ALU operand 2.
- alu_ctrl  out  3  ALU control.
- alu_out  in  DATA_WIDTH  ALU sum, same cycle.
- alu_eq  in  1  ALU equality flag, same cycle.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, P_hi=0, M=0, A=0, cnt=0, hi_sel=0, resp_valid=0, resp_data=0, alu_busy=0, alu_op1=0, alu_op2=0, alu_ctrl=3'b000. No response is produced for an aborted operation.
- States: IDLE, ZCHK, RUN, DONE.
- IDLE:
  - req_ready=1, alu_busy=0, ALU outputs at 0/3'b000.
  - On req_valid: latch A=req_a, M=req_b, hi_sel=req_hi, P_hi=0, cnt=0; go to ZCHK.
- ZCHK (1 cycle):
  - alu_busy=1, alu_ctrl=3'b111, alu_op1=M, alu_op2=0.
  - If alu_eq=1: P_hi=0, M=0, go to DONE.
  - Else go to RUN.
  - Zero is checked on the multiplier only; req_a=0 runs the full sequence.
- RUN (exactly DATA_WIDTH cycles):
  - alu_busy=1, alu_ctrl=3'b000, alu_op1=P_hi, alu_op2=A.
  - If M[0]=1: carry=(alu_out < P_hi) unsigned, computed locally; {P_hi,M} <= {carry,alu_out,M}>>1.
  - If M[0]=0: {P_hi,M} <= {1'b0,P_hi,M}>>1.
  - cnt increments each cycle. After the iteration with cnt=DATA_WIDTH-1, go to DONE.
- DONE:
  - resp_valid=1, resp_data = hi_sel ? P_hi : M. resp_data is stable while waiting.
  - alu_busy=0.
  - On resp_ready: go to IDLE, resp_valid=0 next cycle.
- Latency, counted in rising edges from the accept edge to the first resp_valid=1 cycle:
  - Zero multiplier: 2.
  - Otherwise: DATA_WIDTH+2, i.e. 34.
- Back-to-back requests: a new request is accepted no earlier than the edge after the response handshake (one IDLE cycle minimum).
- kill:
  - In ZCHK, RUN or DONE: go to IDLE next edge; resp_valid drops; the result is discarded.
  - In IDLE: ignored, and it blocks acceptance that cycle.
  - kill wins over req_valid and resp_ready.
- req_a, req_b and req_hi are sampled only at accept; later changes have no effect.
- Arithmetic is unsigned modulo 2^(2*DATA_WIDTH); the product never overflows 64 bits.

Test Plan:
- Reset mid-RUN: assert rst_n=0 at iteration 10 → all outputs at reset values immediately; no resp_valid after release; the next request 6*7 returns 42.
- req_a=3, req_b=5, req_hi=0 → resp_data=15, resp_valid rises 34 edges after accept; alu_ctrl=3'b111 for 1 cycle, then 3'b000 for 32 cycles.
- req_a=req_b=32'hFFFFFFFF: req_hi=1 → 32'hFFFFFFFE; req_hi=0 → 32'h00000001.
- req_a=7, req_b=0 → resp_data=0 with resp_valid 2 edges after accept. Repeat with req_a=0, req_b=9 → 0 after 34 edges.
- Hold resp_ready=0 for 5 cycles after 0x10000*0x10000, req_hi=1 → resp_data=1 held stable and req_ready=0 throughout; accepted on resp_ready; req_ready=1 next cycle.
- kill at RUN iteration 3 → IDLE next edge, no resp_valid. kill and req_valid together in IDLE → not accepted.
